instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the 9-bit pipelined CPU. It owns the program counter and issues addresses to a synchronous instruction ROM. It presents one registered 9-bit instruction per cycle to the decoder's `instruction_in`. It consumes the decoder's halt indication and the resolved branch outcome, squashing wrong-path fetches and freezing on halt.

## Interface
Parameters:
- `PC_WIDTH`, 8, width of program counter and ROM address.
- `BUBBLE_WORD`, 9'b110110000, word driven while no valid instruction is presented (opcode 11011, reserved).

Ports:
- `clk`, input, 1, single clock; all state updates on rising edge.
- `reset`, input, 1, synchronous, active-high.
- `start_req`, input, 1, begin execution at address 0; honoured in IDLE and HALTED.
- `halt`, input, 1, decoder's halt flag for the instruction currently on `instruction_out`.
- `branch_taken`, input, 1, resolved branch/jump outcome for the instruction currently on `instruction_out`.
- `branch_target`, input, PC_WIDTH, absolute target address, sampled with `branch_taken`.
- `imem_addr`, output, PC_WIDTH, ROM read address, equal to the fetch PC register.
- `imem_data`, input, 9, ROM word for the address presented one cycle earlier.
- `instruction_out`, output, 9, registered instruction to the decoder.
- `instr_valid`, output, 1, `instruction_out` is a real instruction; downstream gates all writes with it.
- `pc_out`, output, PC_WIDTH, address of the word on `instruction_out`.
- `done`, output, 1, high while in HALTED.
- `retired_cnt`, output, 16, only with `IFETCH_PERF_CNT_EN`.

## Operation
- Registers: `fetch_pc`, a 2-stage address pipeline (`a1`, `a2`) with valid bits (`v1`, `v2`), `squash` (2-bit), state.
- States: IDLE, RUN, HALTED.
- IDLE:
  - `fetch_pc`=0, `imem_addr`=0.
  - `start_req` -> RUN; `v1` set that edge.
- RUN, every cycle:
  - `fetch_pc` increments, wrapping 2^PC_WIDTH-1 -> 0 with no flag.
  - `a1`<=`fetch_pc`, `a2`<=`a1`.
  - `instruction_out`<=`imem_data` if `v2` and `squash`==0, otherwise BUBBLE_WORD with `instr_valid`=0.
  - `pc_out`<=`a2`.
- Taken branch (`branch_taken` & `instr_valid`):
  - `fetch_pc`<=`branch_target`.
  - `v1`, `v2` cleared (two wrong-path words discarded).
- Halt (`halt` & `instr_valid`):
  - -> HALTED.
  - `fetch_pc` frozen; `instruction_out`<=BUBBLE_WORD; `instr_valid`<=0; `done`<=1.
  - Pipeline valids cleared.
- HALTED:
  - Outputs held.
  - `start_req` -> RUN from address 0; `done` clears the same edge.
- `halt` or `branch_taken` while `instr_valid`=0: ignored.
- `halt` and `branch_taken` together: halt wins; branch ignored.
- `start_req` in RUN: ignored.
- Reset mid-operation: all state returns to reset values next edge; in-flight ROM data discarded.

## Timing
- Reset values:
  - State IDLE, `fetch_pc`=0, `imem_addr`=0.
  - `instruction_out`=BUBBLE_WORD, `instr_valid`=0, `pc_out`=0, `done`=0, `retired_cnt`=0.
- Start latency: `start_req` sampled at edge E0.
  - Address 0 on `imem_addr` in cycle after E0.
  - Instruction 0 on `instruction_out` with `instr_valid`=1 two edges later (E2).
- Steady state: one instruction per cycle; `pc_out` increments by 1.
- Branch penalty: branch resolved in cycle k.
  - Cycles k+1 and k+2 are bubbles.
  - Target instruction valid in cycle k+3.
- Halt: `done`=1 and `instr_valid`=0 in cycle after halt presented.
- No combinational path from any input to any output except `imem_addr` (registered `fetch_pc`).

## Configuration
- `IFETCH_PERF_CNT_EN` defined:
  - `retired_cnt` port present.
  - Increments by 1 each cycle `instr_valid`=1 and `halt`=0.
  - Saturates at 16'hFFFF.
  - Clears on reset and on `start_req` acceptance.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset, then `start_req` pulse, ROM words 0..3 = 9'h001,9'h002,9'h003,9'h004 -> `instruction_out` 001,002,003,004 on consecutive cycles from E2; `pc_out` 0,1,2,3.
- `branch_taken`=1, `branch_target`=8'h40 when `pc_out`=5 -> two cycles `instr_valid`=0 with BUBBLE_WORD, then `pc_out`=8'h40 with ROM[0x40].
- `halt`=1 when `pc_out`=7 -> next cycle `done`=1, `instr_valid`=0, `imem_addr` constant for 10 cycles; `start_req` -> restart at pc 0.
- `halt` and `branch_taken` both high at `pc_out`=3 -> HALTED; no target fetch; `done`=1.
- `PC_WIDTH`=4, run from 0 straight through -> `pc_out` sequence 14,15,0,1 with `instr_valid` continuously 1.
- Reset asserted one cycle after a taken branch -> next cycle all outputs at reset values; `retired_cnt`=0 with `IFETCH_PERF_CNT_EN`.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: program counter and fetch front end for the 9-bit pipelined CPU.
//
// Drives a synchronous instruction ROM. Each cycle it presents one registered
// instruction to the decoder, or BUBBLE_WORD when no valid word is available.
// It squashes wrong-path words after a taken branch and freezes when the decoder
// reports a halt.
//
// Ports:
//   clk, reset        single clock; synchronous active-high reset
//   start_req         begin execution at address 0 (from IDLE or HALTED)
//   halt              decoder halt flag for the word on instruction_out
//   branch_taken      resolved branch outcome for the word on instruction_out
//   branch_target     absolute target, sampled with branch_taken
//   imem_addr         ROM read address (registered fetch PC)
//   imem_data         ROM word for the address presented one cycle earlier
//   instruction_out   registered instruction to the decoder
//   instr_valid       instruction_out is a real instruction
//   pc_out            address of the word on instruction_out
//   done              high while halted
//   retired_cnt       retired-instruction counter, present only when
//                     IFETCH_PERF_CNT_EN is defined
//
// Optional feature macro: IFETCH_PERF_CNT_EN
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | after reset, waiting for start_req; fetch PC parked at 0
// S_RUN    | fetching one word per cycle
// S_HALTED | decoder halted; outputs frozen until start_req
module instr_fetch #(
  parameter int         PC_WIDTH    = 8,
  parameter logic [8:0] BUBBLE_WORD = 9'b110110000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_req,
  input  logic                halt,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [8:0]          imem_data,
  output logic [8:0]          instruction_out,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                done
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [15:0]         retired_cnt
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] a2_q, a2_d;
  logic                v1_q, v1_d;
  logic                v2_q, v2_d;
  logic [8:0]          instr_q, instr_d;
  logic                valid_q, valid_d;
  logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
  logic                done_q, done_d;

  logic accept_start;
  logic take_halt;
  logic take_branch;

  assign accept_start = start_req && (state_q != S_RUN);
  // Halt and branch only act on a real instruction; halt has priority.
  assign take_halt    = (state_q == S_RUN) && valid_q && halt;
  assign take_branch  = (state_q == S_RUN) && valid_q && branch_taken && !halt;

  // fetch_pc_q is the first address stage: it is the address the ROM is
  // latching this cycle, qualified by v1_q. a2_q/v2_q track the address whose
  // data is on imem_data now.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    a2_d       = a2_q;
    v1_d       = v1_q;
    v2_d       = v2_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    pc_out_d   = pc_out_q;
    done_d     = done_q;

    case (state_q)
      S_RUN: begin
        if (take_halt) begin
          state_d = S_HALTED;
          instr_d = BUBBLE_WORD;
          valid_d = 1'b0;
          done_d  = 1'b1;
          v1_d    = 1'b0;
          v2_d    = 1'b0;
        end else begin
          pc_out_d = a2_q;
          a2_d     = fetch_pc_q;
          // The word arriving in the branch cycle is already wrong-path, so
          // it is dropped here; the next one is dropped by clearing v2.
          if (v2_q && !take_branch) begin
            instr_d = imem_data;
            valid_d = 1'b1;
          end else begin
            instr_d = BUBBLE_WORD;
            valid_d = 1'b0;
          end
          if (take_branch) begin
            fetch_pc_d = branch_target;
            v2_d       = 1'b0;
          end else begin
            fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
            v2_d       = v1_q;
          end
        end
      end
      S_IDLE, S_HALTED: begin
        if (accept_start) begin
          state_d    = S_RUN;
          fetch_pc_d = '0;
          v1_d       = 1'b1;
          v2_d       = 1'b0;
          done_d     = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= '0;
      a2_q       <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      instr_q    <= BUBBLE_WORD;
      valid_q    <= 1'b0;
      pc_out_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      a2_q       <= a2_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      pc_out_q   <= pc_out_d;
      done_q     <= done_d;
    end
  end

  assign imem_addr       = fetch_pc_q;
  assign instruction_out = instr_q;
  assign instr_valid     = valid_q;
  assign pc_out          = pc_out_q;
  assign done            = done_q;

`ifdef IFETCH_PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept_start) begin
      cnt_d = '0;
    end else if (valid_q && !halt && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retired_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam logic [8:0] BUBBLE = 9'b110110000;
  localparam int MODE_IDLE = 0;
  localparam int MODE_RUN  = 1;
  localparam int MODE_HALT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_req, halt, branch_taken;
  logic [7:0] branch_target;
  logic [7:0] imem_addr;
  logic [8:0] imem_data;
  logic [8:0] instruction_out;
  logic       instr_valid;
  logic [7:0] pc_out;
  logic       done;

  logic       start4;
  logic [3:0] imem_addr4;
  logic [8:0] imem_data4;
  logic [8:0] instruction4;
  logic       valid4;
  logic [3:0] pc_out4;
  logic       done4;

`ifdef IFETCH_PERF_CNT_EN
  logic [15:0] retired_cnt;
  logic [15:0] retired_cnt4;
`endif

  logic [8:0] rom [256];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected stream of retired addresses and bubbles.
  int         m_mode;
  logic       m_valid;
  logic       m_done;
  logic [7:0] m_addr;
  logic [7:0] m_pc;
  logic [7:0] m_next;
  int         m_bub;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  instr_fetch #(.PC_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start_req(start_req), .halt(halt),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .instruction_out(instruction_out), .instr_valid(instr_valid),
    .pc_out(pc_out), .done(done)
`ifdef IFETCH_PERF_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  instr_fetch #(.PC_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start_req(start4), .halt(1'b0),
    .branch_taken(1'b0), .branch_target(4'h0),
    .imem_addr(imem_addr4), .imem_data(imem_data4),
    .instruction_out(instruction4), .instr_valid(valid4),
    .pc_out(pc_out4), .done(done4)
`ifdef IFETCH_PERF_CNT_EN
    , .retired_cnt(retired_cnt4)
`endif
  );

  // Synchronous ROMs.
  always @(posedge clk) begin
    imem_data  <= rom[imem_addr];
    imem_data4 <= {5'b0, imem_addr4};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic out_step();
    if (m_bub > 0) begin
      m_bub--;
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b1;
      m_pc    = m_next;
      m_next  = m_next + 8'd1;
    end
    m_addr = m_next + 8'(1 - m_bub);
  endtask

  task automatic model_edge(input logic st, input logic h, input logic b,
                            input logic [7:0] tgt, input logic rst);
    if (rst) begin
      m_mode = MODE_IDLE; m_valid = 1'b0; m_done = 1'b0; m_addr = 8'd0;
      m_pc = 8'd0; m_next = 8'd0; m_bub = 0; m_cnt = 16'd0;
    end else begin
      if (m_valid && !h && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_mode == MODE_RUN) begin
        if (m_valid && h) begin
          m_mode  = MODE_HALT;
          m_valid = 1'b0;
          m_done  = 1'b1;
        end else begin
          if (m_valid && b) begin
            m_next = tgt;
            m_bub  = 2;
          end
          out_step();
        end
      end else if (st) begin
        m_mode = MODE_RUN;
        m_done = 1'b0;
        m_next = 8'd0;
        m_bub  = 2;
        m_cnt  = 16'd0;
        out_step();
      end
    end
  endtask

  task automatic check_all();
    chk("instr_valid", instr_valid, m_valid);
    chk("done", done, m_done);
    chk("imem_addr", imem_addr, m_addr);
    if (m_valid) begin
      chk("pc_out", pc_out, m_pc);
      chk("instruction", instruction_out, rom[m_pc]);
    end else begin
      chk("bubble_word", instruction_out, BUBBLE);
    end
    if (m_mode == MODE_IDLE) chk("pc_out_idle", pc_out, 0);
    if (m_mode == MODE_HALT) chk("pc_out_halted", pc_out, m_pc);
`ifdef IFETCH_PERF_CNT_EN
    chk("retired_cnt", retired_cnt, m_cnt);
`endif
  endtask

  task automatic step(input logic st, input logic h, input logic b,
                      input logic [7:0] tgt, input logic rst);
    start_req = st; halt = h; branch_taken = b; branch_target = tgt; reset = rst;
    @(posedge clk);
    model_edge(st, h, b, tgt, rst);
    #1;
    check_all();
  endtask

  task automatic run_until(input logic [7:0] p);
    int i = 0;
    while (!(m_valid && m_pc == p) && i < 600) begin
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      i++;
    end
    n_checks++;
    assert (m_valid && m_pc == p) else begin
      n_fail++;
      $error("FAIL run_until: pc %0h not reached, observed pc_out %0h", p, pc_out);
    end
  endtask

  initial begin
    start_req = 0; halt = 0; branch_taken = 0; branch_target = 0; reset = 1; start4 = 0;
    for (int i = 0; i < 256; i++) rom[i] = 9'($urandom);
    rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003; rom[3] = 9'h004;

    // Reset values.
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 0);

    // Start, straight-line fetch, branch at pc 5 to 0x40.
    step(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 8'h00, 0);
    run_until(8'h05);
    step(0, 0, 1, 8'h40, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 0);

    // Halt at pc 0x45, hold for 10 cycles, then restart.
    run_until(8'h45);
    step(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);

    // Halt together with branch: halt wins.
    run_until(8'h03);
    step(0, 1, 1, 8'h80, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 0);

    // Start in RUN ignored; branch then reset one cycle later.
    step(1, 0, 0, 8'h00, 0);
    run_until(8'h02);
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'h10, 0);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 0);

    // Randomized traffic.
    step(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(7) == 0), ($urandom_range(24) == 0),
           ($urandom_range(5) == 0), 8'($urandom), ($urandom_range(199) == 0));
    end

    // PC wrap on a 4-bit fetch unit.
    step(0, 0, 0, 8'h00, 1);
    start4 = 1;
    step(0, 0, 0, 8'h00, 0);
    start4 = 0;
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 20; i++) begin
      chk("w4_valid", valid4, 1);
      chk("w4_pc_out", pc_out4, 32'(i % 16));
      chk("w4_instr", instruction4, 32'(i % 16));
      chk("w4_done", done4, 0);
      step(0, 0, 0, 8'h00, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
